// File: rtl/timer_sched_pkg.sv
// rtl/timer_sched_pkg.sv - shared definitions for the shared delay-timer scheduler
//
// Purpose: state encodings for the scheduler FSM and the round-robin pick
// function used by rr_arbiter. Request vectors are handled here at the
// maximum supported width (8) so the function needs no parameters.
package timer_sched_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // First set bit of req at or after ptr, wrapping modulo n (n = active
  // requesters, 2..8). Bits of req at or above n must be zero.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input logic [3:0] n);
    logic [3:0] idx;
    logic       found;
    rr_pick = 3'd0;
    found   = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      // ptr < n and k < n, so a single subtraction completes the wrap
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= n) idx = idx - n;
      if (!found && (4'(k) < n) && req[idx[2:0]]) begin
        rr_pick = idx[2:0];
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/shared_timer_sched_rr_arbiter.sv
// rtl/shared_timer_sched_rr_arbiter.sv - round-robin arbiter with registered pointer
//
// Purpose: combinational winner selection starting at a registered pointer;
// the pointer moves to one past the last served requester on an update strobe.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   req       level requests
//   upd       strobe: advance pointer past win
//   win       index of the requester just served or aborted
//   pick      combinational winner index for the current req/pointer
//   any       at least one request pending
module rr_arbiter
  import timer_sched_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             upd,
  input  logic [2:0]       win,
  output logic [2:0]       pick,
  output logic             any
);

  logic [2:0] ptr_q;
  logic [7:0] req_ext;

  always_comb begin
    req_ext            = '0;
    req_ext[N_REQ-1:0] = req;
  end

  assign pick = rr_pick(req_ext, ptr_q, 4'(N_REQ));
  assign any  = |req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 3'd0;
    end else if (upd) begin
      ptr_q <= (win == 3'(N_REQ - 1)) ? 3'd0 : win + 3'd1;
    end
  end

endmodule

// File: rtl/shared_timer_sched.sv
// rtl/shared_timer_sched.sv - one delay timer shared round-robin between requesters
//
// Purpose: grants one requester at a time a one-shot window of max(len,1)
// cycles, then pulses its done flag. Dropping the request mid-window aborts
// it without a done pulse.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   req       level request per requester, held until done
//   len       packed delay lengths, slice i = len[i*W +: W], sampled at grant
//   gnt       one-hot grant, high for the whole window
//   done      one-cycle completion pulse to the served requester
//   busy      a window (RUN or DONE) is in progress
module shared_timer_sched
  import timer_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] len,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic               busy
);

  state_t           state_q, state_n;
  logic [2:0]       win_q, win_n;
  logic [W-1:0]     cnt_q, cnt_n;
  logic [N_REQ-1:0] gnt_q, gnt_n;
  logic [N_REQ-1:0] done_q, done_n;
  logic [7:0]       req_ext;
  logic [2:0]       pick;
  logic             any;
  logic             upd;
  logic [W-1:0]     len_sel;
  logic [N_REQ-1:0] pick_oh;
  logic [N_REQ-1:0] win_oh;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .upd  (upd),
    .win  (win_q),
    .pick (pick),
    .any  (any)
  );

  always_comb begin
    req_ext            = '0;
    req_ext[N_REQ-1:0] = req;
  end

  always_comb begin
    len_sel = '0;
    pick_oh = '0;
    win_oh  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick == 3'(i)) begin
        len_sel    = len[i*W +: W];
        pick_oh[i] = 1'b1;
      end
      if (win_q == 3'(i)) win_oh[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      win_q   <= 3'd0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_n;
      win_q   <= win_n;
      cnt_q   <= cnt_n;
      gnt_q   <= gnt_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state_q;
    win_n   = win_q;
    cnt_n   = cnt_q;
    gnt_n   = gnt_q;
    done_n  = '0;
    upd     = 1'b0;
    case (state_q)
      S_IDLE: begin
        gnt_n = '0;
        if (any) begin
          state_n = S_RUN;
          win_n   = pick;
          gnt_n   = pick_oh;
          // zero-length requests still get a one-cycle window
          cnt_n   = (len_sel == '0) ? W'(1) : len_sel;
        end
      end
      S_RUN: begin
        // abort takes priority over completion, even on the last cycle
        if (!req_ext[win_q]) begin
          state_n = S_IDLE;
          gnt_n   = '0;
          upd     = 1'b1;
        end else if (cnt_q == W'(1)) begin
          state_n = S_DONE;
          gnt_n   = '0;
          done_n  = win_oh;
        end else begin
          cnt_n = cnt_q - W'(1);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        gnt_n   = '0;
        upd     = 1'b1;
      end
      default: begin
        state_n = S_IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = (state_q != S_IDLE);

endmodule
